fib_seq_engine: RTL and testbench



---
 rtl/fib_seq_pkg.sv | 13 +
 rtl/fib_seq_step.sv | 28 ++
 rtl/fib_seq_engine.sv | 163 ++++++++++++++++
 tb/tb_fib_seq_engine.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_seq_pkg.sv
// Shared types and default widths for the fib_seq_engine compute leaf.
package fib_seq_pkg;

  localparam int W_DEF  = 32;
  localparam int NW_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : fib_seq_pkg

// File: rtl/fib_seq_step.sv
// One recurrence step: W+1-bit sum of a and b, optionally reduced by a single
// conditional subtract of the modulus.
module fib_seq_step
  import fib_seq_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  input  logic         mod_active,
  output logic [W-1:0] next_a,
  output logic         carry
);

  logic [W:0] sum;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    next_a = sum[W-1:0];
    carry  = sum[W] & ~mod_active;
    // Low W bits of (sum - m) equal sum[W-1:0] - m modulo 2^W.
    if (mod_active && (sum >= {1'b0, m})) begin
      next_a = sum[W-1:0] - m;
    end
  end

endmodule : fib_seq_step

// File: rtl/fib_seq_engine.sv
// Two-term recurrence engine with r_enable start / w_enable done handshake.
// Optional per-step trace outputs are enabled by defining FIB_SEQ_TRACE_EN.
module fib_seq_engine
  import fib_seq_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int NW = NW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r_enable,
  input  logic [NW-1:0] init_n,
  input  logic [W-1:0]  init_a,
  input  logic [W-1:0]  init_b,
  input  logic          mod_en,
  input  logic [W-1:0]  modulus,
  output logic          w_enable,
  output logic [W-1:0]  result,
  output logic          overflow,
  output logic          busy
`ifdef FIB_SEQ_TRACE_EN
  ,
  output logic          step_valid,
  output logic [W-1:0]  step_value
`endif
);

  state_t        state_reg, state_next;
  logic [W-1:0]  a_reg, a_next;
  logic [W-1:0]  b_reg, b_next;
  logic [NW-1:0] cnt_reg, cnt_next;
  logic          mod_reg, mod_next;
  logic [W-1:0]  m_reg, m_next;
  logic [W-1:0]  result_reg, result_next;
  logic          ovf_reg, ovf_next;

  logic [W-1:0]  step_a;
  logic          step_carry;

`ifdef FIB_SEQ_TRACE_EN
  logic          step_valid_reg, step_valid_next;
  logic [W-1:0]  step_value_reg, step_value_next;
`endif

  fib_seq_step #(
    .W(W)
  ) u_step (
    .a         (a_reg),
    .b         (b_reg),
    .m         (m_reg),
    .mod_active(mod_reg),
    .next_a    (step_a),
    .carry     (step_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      cnt_reg    <= '0;
      mod_reg    <= 1'b0;
      m_reg      <= '0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      cnt_reg    <= cnt_next;
      mod_reg    <= mod_next;
      m_reg      <= m_next;
      result_reg <= result_next;
      ovf_reg    <= ovf_next;
    end
  end

`ifdef FIB_SEQ_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      step_valid_reg <= 1'b0;
      step_value_reg <= '0;
    end else begin
      step_valid_reg <= step_valid_next;
      step_value_reg <= step_value_next;
    end
  end
`endif

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    cnt_next    = cnt_reg;
    mod_next    = mod_reg;
    m_next      = m_reg;
    result_next = result_reg;
    ovf_next    = ovf_reg;
`ifdef FIB_SEQ_TRACE_EN
    step_valid_next = 1'b0;
    step_value_next = step_value_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (r_enable) begin
          a_next   = init_a;
          b_next   = init_b;
          cnt_next = init_n;
          // A zero modulus degrades to plain wrap-around arithmetic.
          mod_next = mod_en && (modulus != '0);
          m_next   = modulus;
          ovf_next = 1'b0;
          if (init_n == '0) begin
            state_next  = DONE;
            result_next = init_a;
          end else begin
            state_next = RUN;
          end
        end
      end

      RUN: begin
        a_next   = step_a;
        b_next   = a_reg;
        cnt_next = cnt_reg - NW'(1);
        ovf_next = ovf_reg | step_carry;
`ifdef FIB_SEQ_TRACE_EN
        step_valid_next = 1'b1;
        step_value_next = step_a;
`endif
        // Result is captured on the DONE entry edge so it is valid with w_enable.
        if (cnt_reg == NW'(1)) begin
          state_next  = DONE;
          result_next = step_a;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    w_enable = (state_reg == DONE);
    busy     = (state_reg != IDLE);
    result   = result_reg;
    overflow = ovf_reg;
  end

`ifdef FIB_SEQ_TRACE_EN
  always_comb begin
    step_valid = step_valid_reg;
    step_value = step_value_reg;
  end
`endif

endmodule : fib_seq_engine

// File: tb/tb_fib_seq_engine.sv
// Scoreboard bench for fib_seq_engine: expected results are queued at each
// start and popped when the w_enable pulse is observed.
module tb_fib_seq_engine;

  localparam int W  = 32;
  localparam int NW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r_enable = 1'b0;
  logic [NW-1:0] init_n = '0;
  logic [W-1:0]  init_a = '0;
  logic [W-1:0]  init_b = '0;
  logic          mod_en = 1'b0;
  logic [W-1:0]  modulus = '0;
  logic          w_enable;
  logic [W-1:0]  result;
  logic          overflow;
  logic          busy;
`ifdef FIB_SEQ_TRACE_EN
  logic          step_valid;
  logic [W-1:0]  step_value;
`endif

  fib_seq_engine #(
    .W (W),
    .NW(NW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .r_enable(r_enable),
    .init_n  (init_n),
    .init_a  (init_a),
    .init_b  (init_b),
    .mod_en  (mod_en),
    .modulus (modulus),
    .w_enable(w_enable),
    .result  (result),
    .overflow(overflow),
    .busy    (busy)
`ifdef FIB_SEQ_TRACE_EN
    ,
    .step_valid(step_valid),
    .step_value(step_value)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Drive a start at a negedge; returns at the negedge right after the accepting edge.
  task automatic start_run(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic me, input logic [W-1:0] m);
    @(negedge clk);
    r_enable = 1'b1;
    init_n   = NW'(n);
    init_a   = a;
    init_b   = b;
    mod_en   = me;
    modulus  = m;
    @(posedge clk);
    @(negedge clk);
    r_enable = 1'b0;
    init_n   = NW'($urandom);
    init_a   = $urandom;
    init_b   = $urandom;
    mod_en   = 1'b0;
    modulus  = $urandom;
  endtask

  task automatic wait_done(input int budget, output bit found, output int k);
    k = 0;
    while (w_enable !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    found = (w_enable === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (w_enable !== 1'b0) $display("FAIL reset_w_enable: got %b want 0", w_enable); else n_pass++;
    n_checks++; if (result !== '0) $display("FAIL reset_result: got %0d want 0", result); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    rst = 1'b0;
    $display("reset: w_enable=%b result=%0d overflow=%b busy=%b", w_enable, result, overflow, busy);
  endtask

  task automatic test_basic();
    exp_t e;
    bit   found;
    int   k;
    sb.push_back('{res: 32'd165580141, ovf: 1'b0, lat: 40});
    start_run(40, 32'd1, 32'd0, 1'b0, 32'd0);
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy_run: got %b want 1", busy); else n_pass++;
    wait_done(80, found, k);
    e = sb.pop_front();
    n_checks++; if (!found) $display("FAIL basic_done: no w_enable within 80 cycles"); else n_pass++;
    n_checks++; if (k != e.lat) $display("FAIL basic_latency: got %0d want %0d", k, e.lat); else n_pass++;
    n_checks++; if (result !== e.res) $display("FAIL basic_result: got %0d want %0d", result, e.res); else n_pass++;
    n_checks++; if (overflow !== e.ovf) $display("FAIL basic_overflow: got %b want %b", overflow, e.ovf); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy_done: got %b want 1", busy); else n_pass++;
    $display("basic n=40: latency=%0d result=%0d overflow=%b", k, result, overflow);
    @(negedge clk);
    n_checks++; if (w_enable !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_after_done: got w_enable=%b busy=%b want 0 0", w_enable, busy); else n_pass++;
    n_checks++; if (result !== e.res) $display("FAIL basic_result_held: got %0d want %0d", result, e.res); else n_pass++;
  endtask

  task automatic test_zero();
    exp_t e;
    bit   found;
    int   k;
    sb.push_back('{res: 32'd1, ovf: 1'b0, lat: 0});
    start_run(0, 32'd1, 32'd0, 1'b0, 32'd0);
    wait_done(5, found, k);
    e = sb.pop_front();
    n_checks++; if (!found) $display("FAIL zero_done: no w_enable within 5 cycles"); else n_pass++;
    n_checks++; if (k != e.lat) $display("FAIL zero_latency: got %0d want %0d", k, e.lat); else n_pass++;
    n_checks++; if (result !== e.res) $display("FAIL zero_result: got %0d want %0d", result, e.res); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL zero_busy: got %b want 1", busy); else n_pass++;
    $display("zero n=0: latency=%0d result=%0d", k, result);
  endtask

  task automatic test_overflow();
    int   ns[3]        = '{46, 47, 46};
    logic [W-1:0] rs[3] = '{32'd2971215073, 32'd512559680, 32'd2971215073};
    logic os[3]        = '{1'b0, 1'b1, 1'b0};
    exp_t e;
    bit   found;
    int   k;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{res: rs[i], ovf: os[i], lat: ns[i]});
      start_run(ns[i], 32'd1, 32'd0, 1'b0, 32'd0);
      if (i == 2) begin
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_cleared_on_start: got %b want 0", overflow); else n_pass++;
      end
      wait_done(80, found, k);
      e = sb.pop_front();
      n_checks++; if (!found) $display("FAIL ovf_done_%0d: no w_enable", i); else n_pass++;
      n_checks++; if (k != e.lat) $display("FAIL ovf_latency_%0d: got %0d want %0d", i, k, e.lat); else n_pass++;
      n_checks++; if (result !== e.res) $display("FAIL ovf_result_%0d: got %0d want %0d", i, result, e.res); else n_pass++;
      n_checks++; if (overflow !== e.ovf) $display("FAIL ovf_flag_%0d: got %b want %b", i, overflow, e.ovf); else n_pass++;
      $display("overflow n=%0d: result=%0d overflow=%b", ns[i], result, overflow);
    end
  endtask

  task automatic test_modular();
    logic [W-1:0] ms[2] = '{32'd7, 32'd0};
    logic [W-1:0] rs[2] = '{32'd5, 32'd89};
    exp_t e;
    bit   found;
    int   k;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{res: rs[i], ovf: 1'b0, lat: 10});
      start_run(10, 32'd1, 32'd0, 1'b1, ms[i]);
      wait_done(30, found, k);
      e = sb.pop_front();
      n_checks++; if (!found) $display("FAIL mod_done_%0d: no w_enable", i); else n_pass++;
      n_checks++; if (result !== e.res) $display("FAIL mod_result_%0d: got %0d want %0d", i, result, e.res); else n_pass++;
      n_checks++; if (overflow !== e.ovf) $display("FAIL mod_overflow_%0d: got %b want %b", i, overflow, e.ovf); else n_pass++;
      $display("modular m=%0d n=10: result=%0d overflow=%b", ms[i], result, overflow);
    end
  endtask

  task automatic test_ignore();
    exp_t e;
    bit   found;
    int   k;
    int   extra = 0;
    sb.push_back('{res: 32'd10946, ovf: 1'b0, lat: 20});
    start_run(20, 32'd1, 32'd0, 1'b0, 32'd0);
    repeat (4) @(negedge clk);
    r_enable = 1'b1; init_n = NW'(3); init_a = 32'd1; init_b = 32'd0;
    @(negedge clk);
    r_enable = 1'b0;
    wait_done(40, found, k);
    k += 5;
    e = sb.pop_front();
    n_checks++; if (!found) $display("FAIL ignore_done: no w_enable"); else n_pass++;
    n_checks++; if (k != e.lat) $display("FAIL ignore_latency: got %0d want %0d", k, e.lat); else n_pass++;
    n_checks++; if (result !== e.res) $display("FAIL ignore_result: got %0d want %0d", result, e.res); else n_pass++;
    r_enable = 1'b1; init_n = NW'(3);
    @(negedge clk);
    r_enable = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (w_enable === 1'b1 || busy === 1'b1) extra++;
      @(negedge clk);
    end
    n_checks++; if (extra != 0) $display("FAIL ignore_no_restart: got %0d busy/done cycles want 0", extra); else n_pass++;
    $display("ignore n=20: latency=%0d result=%0d extra=%0d", k, result, extra);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   pulses = 0;
    int   pos[2] = '{-1, -1};
    sb.push_back('{res: 32'd3, ovf: 1'b0, lat: 2});
    sb.push_back('{res: 32'd3, ovf: 1'b0, lat: 6});
    @(negedge clk);
    r_enable = 1'b1; init_n = NW'(2); init_a = 32'd1; init_b = 32'd1; mod_en = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (w_enable === 1'b1) begin
        pos[pulses] = k;
        e = sb.pop_front();
        n_checks++; if (k != e.lat) $display("FAIL b2b_latency_%0d: got %0d want %0d", pulses, k, e.lat); else n_pass++;
        n_checks++; if (result !== e.res) $display("FAIL b2b_result_%0d: got %0d want %0d", pulses, result, e.res); else n_pass++;
        pulses++;
        if (pulses == 2) break;
      end
    end
    r_enable = 1'b0;
    n_checks++; if (pulses != 2) $display("FAIL b2b_pulses: got %0d want 2", pulses); else n_pass++;
    if (pulses < 2) sb.delete();
    $display("back_to_back n=2: pulses at %0d,%0d result=%0d", pos[0], pos[1], result);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_rst_midrun();
    exp_t e;
    bit   found;
    int   k;
    int   stray = 0;
    start_run(30, 32'd1, 32'd0, 1'b0, 32'd0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (result !== '0) $display("FAIL rst_result: got %0d want 0", result); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", overflow); else n_pass++;
    for (int c = 0; c < 30; c++) begin
      if (w_enable === 1'b1) stray++;
      @(negedge clk);
    end
    n_checks++; if (stray != 0) $display("FAIL rst_no_pulse: got %0d pulses want 0", stray); else n_pass++;
    sb.push_back('{res: 32'd8, ovf: 1'b0, lat: 5});
    start_run(5, 32'd1, 32'd0, 1'b0, 32'd0);
    wait_done(20, found, k);
    e = sb.pop_front();
    n_checks++; if (!found) $display("FAIL rst_restart_done: no w_enable"); else n_pass++;
    n_checks++; if (k != e.lat) $display("FAIL rst_restart_latency: got %0d want %0d", k, e.lat); else n_pass++;
    n_checks++; if (result !== e.res) $display("FAIL rst_restart_result: got %0d want %0d", result, e.res); else n_pass++;
    $display("rst_midrun: stray=%0d restart result=%0d", stray, result);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_overflow();
    test_modular();
    test_ignore();
    test_back_to_back();
    test_rst_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fib_seq_engine
